// File: rtl/rr_arbiter_generic.sv
// Round-robin arbiter for 2**N requesters sharing one resource.
// A rotating-priority search starting at ptr picks the next owner. The grant
// is registered one-hot and held until the owner drops its request or the
// hold limit runs out. There is always one idle cycle between two grants.
//
// Handshake: req[k] is a level request held until served. gnt[k] is high
// while agent k owns the resource. The owner releases by dropping req[k].
// The arbiter takes the grant away after MAX_HOLD cycles (MAX_HOLD != 0)
// even if req[k] is still high. gnt_id/gnt_valid mirror gnt for the datapath
// select mux.
module rr_arbiter_generic #(
  parameter int N        = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2**N-1:0]   req,
  output logic [2**N-1:0]   gnt,
  output logic [N-1:0]      gnt_id,
  output logic              gnt_valid,
  output logic              none,
  output logic              dbg_state
);

  localparam int R  = 2**N;
  localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [R-1:0]    gnt_nxt;
  logic [N-1:0]    id_nxt;
  logic            valid_nxt;
  logic [N-1:0]    ptr, ptr_nxt;
  logic [HW-1:0]   hold_cnt, hold_nxt;

  logic            pick_found;
  logic [N-1:0]    pick_id;
  logic [N-1:0]    cand;
  logic            owner_drop;
  logic            timeout;

  // Debug view of the FSM: 0 = IDLE, 1 = GRANT.
  assign dbg_state = (state == GRANT);

  // Combinational "no requests" flag.
  assign none = (req == '0);

  // Circular search from ptr: the first requester at or after ptr wins.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int i = 0; i < R; i++) begin
      cand = ptr + N'(i);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  // Release conditions while a grant is active.
  always_comb begin
    owner_drop = !req[gnt_id];
    timeout    = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    id_nxt    = gnt_id;
    valid_nxt = gnt_valid;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt = GRANT;
          gnt_nxt   = R'(1) << pick_id;
          id_nxt    = pick_id;
          valid_nxt = 1'b1;
          hold_nxt  = '0;
        end
      end
      GRANT: begin
        if (owner_drop || timeout) begin
          // Pointer moves past the owner, so a timed-out owner that is
          // still requesting ends up with the lowest priority.
          state_nxt = IDLE;
          gnt_nxt   = '0;
          valid_nxt = 1'b0;
          ptr_nxt   = gnt_id + N'(1);
        end else if (MAX_HOLD != 0) begin
          hold_nxt = hold_cnt + HW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        valid_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers; reset wins over everything, including a live grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      ptr       <= '0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      gnt_id    <= id_nxt;
      gnt_valid <= valid_nxt;
      ptr       <= ptr_nxt;
      hold_cnt  <= hold_nxt;
    end
  end

  // Structural invariants of the grant outputs.
  a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_gnt_valid  : assert property (@(posedge clk) disable iff (!rst_n) gnt_valid == (gnt != '0));

endmodule

// File: tb/tb_rr_arbiter_generic.sv
// Bench for rr_arbiter_generic: one instance with MAX_HOLD=4 for arbitration,
// rotation and reset cases, and one with MAX_HOLD=0 for the unlimited hold case.
// Expected grants {id, length} are queued by the driver and checked by monitors.
module tb_rr_arbiter_generic;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [3:0] req_a, req_b;
  logic [3:0] gnt_a, gnt_b;
  logic [1:0] gnt_id_a, gnt_id_b;
  logic       gnt_valid_a, gnt_valid_b;
  logic       none_a, none_b;
  logic       dbg_a, dbg_b;

  rr_arbiter_generic #(.N(2), .MAX_HOLD(4)) dut_a (
    .clk(clk), .rst_n(rst_a), .req(req_a), .gnt(gnt_a), .gnt_id(gnt_id_a),
    .gnt_valid(gnt_valid_a), .none(none_a), .dbg_state(dbg_a)
  );

  rr_arbiter_generic #(.N(2), .MAX_HOLD(0)) dut_b (
    .clk(clk), .rst_n(rst_b), .req(req_b), .gnt(gnt_b), .gnt_id(gnt_id_b),
    .gnt_valid(gnt_valid_b), .none(none_b), .dbg_state(dbg_b)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [9:0] exp_q_a[$];   // {id[1:0], len[7:0]}
  logic [9:0] exp_q_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_a(input int id, input int len);
    logic [1:0] i;
    logic [7:0] l;
    i = id[1:0];
    l = len[7:0];
    exp_q_a.push_back({i, l});
  endtask

  task automatic push_b(input int id, input int len);
    logic [1:0] i;
    logic [7:0] l;
    i = id[1:0];
    l = len[7:0];
    exp_q_b.push_back({i, l});
  endtask

  task automatic judge(input string tag, input logic has, input logic [9:0] e,
                       input logic [1:0] id, input logic [3:0] g, input int len,
                       input logic ok);
    logic [3:0] one;
    one = 4'b0001;
    check({tag, " grant expected"}, 32'(has), 32'd1);
    if (has) begin
      check({tag, " gnt_id"}, 32'(id), 32'(e[9:8]));
      check({tag, " gnt"}, 32'(g), 32'(one << e[9:8]));
      check({tag, " length"}, 32'(len), 32'(e[7:0]));
      check({tag, " stable"}, 32'(ok), 32'd1);
    end
  endtask

  task automatic close_a(input logic [1:0] id, input logic [3:0] g, input int len, input logic ok);
    logic       has;
    logic [9:0] e;
    has = (exp_q_a.size() > 0);
    e   = has ? exp_q_a.pop_front() : 10'd0;
    judge("a", has, e, id, g, len, ok);
  endtask

  task automatic close_b(input logic [1:0] id, input logic [3:0] g, input int len, input logic ok);
    logic       has;
    logic [9:0] e;
    has = (exp_q_b.size() > 0);
    e   = has ? exp_q_b.pop_front() : 10'd0;
    judge("b", has, e, id, g, len, ok);
  endtask

  // ---------------- monitors ----------------
  logic       in_a = 1'b0, in_b = 1'b0;
  logic [1:0] id_a, id_b;
  logic [3:0] g_a, g_b;
  int         len_a, len_b;
  logic       ok_a, ok_b;

  // Track each grant of instance a from rise to fall; judge it on the fall.
  always @(negedge clk) begin
    if (gnt_valid_a === 1'b1) begin
      if (!in_a) begin
        in_a  <= 1'b1;
        id_a  <= gnt_id_a;
        g_a   <= gnt_a;
        len_a <= 1;
        ok_a  <= (gnt_a === (4'b0001 << gnt_id_a));
      end else begin
        len_a <= len_a + 1;
        if (gnt_a !== g_a || gnt_id_a !== id_a) ok_a <= 1'b0;
      end
    end else if (in_a) begin
      in_a <= 1'b0;
      close_a(id_a, g_a, len_a, ok_a);
    end
  end

  // Same tracking for instance b.
  always @(negedge clk) begin
    if (gnt_valid_b === 1'b1) begin
      if (!in_b) begin
        in_b  <= 1'b1;
        id_b  <= gnt_id_b;
        g_b   <= gnt_b;
        len_b <= 1;
        ok_b  <= (gnt_b === (4'b0001 << gnt_id_b));
      end else begin
        len_b <= len_b + 1;
        if (gnt_b !== g_b || gnt_id_b !== id_b) ok_b <= 1'b0;
      end
    end else if (in_b) begin
      in_b <= 1'b0;
      close_b(id_b, g_b, len_b, ok_b);
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, " gnt"}, 32'(gnt_a), 32'd0);
    check({tag, " gnt_id"}, 32'(gnt_id_a), 32'd0);
    check({tag, " gnt_valid"}, 32'(gnt_valid_a), 32'd0);
  endtask

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    req_a = 4'b1111;
    req_b = 4'b0000;
    tick();
    tick();
    check_reset_a("reset");
    check("reset none", 32'(none_a), 32'd0);
    check("reset dbg_state", 32'(dbg_a), 32'd0);

    // All four request, 4-cycle timeout: 0,1,2,3,0 each 4 cycles, 1 idle between.
    push_a(0, 4); push_a(1, 4); push_a(2, 4); push_a(3, 4); push_a(0, 4);
    rst_a = 1'b1;
    repeat (25) tick();
    req_a = 4'b0000;
    check("rotation end gnt", 32'(gnt_a), 32'd0);
    tick();
    check("idle gnt_valid", 32'(gnt_valid_a), 32'd0);
    check("idle none", 32'(none_a), 32'd1);

    // Reset mid-grant (ptr=1 here): agent 1 drops at the reset edge, then 0 wins.
    push_a(1, 2); push_a(0, 2);
    req_a = 4'b0010;
    tick();
    tick();
    rst_a = 1'b0;
    tick();
    check_reset_a("mid-grant reset");
    rst_a = 1'b1;
    req_a = 4'b0011;
    tick();
    tick();
    req_a = 4'b0000;
    tick();
    tick();

    // Basic from ptr=0: 1010 -> agent 1; drop req[1] -> one idle cycle, then agent 3.
    rst_a = 1'b0;
    tick();
    rst_a = 1'b1;
    tick();
    push_a(1, 3); push_a(3, 2);
    req_a = 4'b1010;
    tick();
    tick();
    tick();
    req_a = 4'b1000;
    tick();
    check("basic gap gnt", 32'(gnt_a), 32'd0);
    tick();
    check("basic second gnt", 32'(gnt_a), 32'b1000);
    tick();
    req_a = 4'b0000;
    tick();
    tick();

    // Wrap: serve agent 2 for one cycle (ptr=3), then 0101 -> agent 0, then agent 2.
    push_a(2, 1); push_a(0, 2); push_a(2, 1);
    req_a = 4'b0100;
    tick();
    req_a = 4'b0000;
    tick();
    req_a = 4'b0101;
    tick();
    tick();
    req_a = 4'b0100;
    tick();
    tick();
    req_a = 4'b0000;
    tick();
    tick();

    // Pointer's own agent (ptr=3) requests alone; afterwards ptr=0 so 1001 -> 0 then 3.
    push_a(3, 2); push_a(0, 1); push_a(3, 1);
    req_a = 4'b1000;
    tick();
    tick();
    req_a = 4'b0000;
    tick();
    tick();
    req_a = 4'b1001;
    tick();
    req_a = 4'b1000;
    tick();
    tick();
    req_a = 4'b0000;
    tick();
    tick();

    // No hold limit: agent 0 keeps the grant for all 20 cycles it requests.
    check("b reset gnt", 32'(gnt_b), 32'd0);
    check("b reset gnt_valid", 32'(gnt_valid_b), 32'd0);
    rst_b = 1'b1;
    tick();
    push_b(0, 20);
    req_b = 4'b0001;
    #1;
    check("b none high req", 32'(none_b), 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("b hold gnt c%0d", i), 32'(gnt_b), 32'b0001);
      check($sformatf("b hold none c%0d", i), 32'(none_b), 32'd0);
    end
    check("b dbg_state grant", 32'(dbg_b), 32'd1);
    req_b = 4'b0000;
    #1;
    check("b none no req", 32'(none_b), 32'd1);
    tick();
    tick();
    tick();

    check("a leftover expected grants", 32'(exp_q_a.size()), 32'd0);
    check("b leftover expected grants", 32'(exp_q_b.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
